// File: rtl/cost_pkg.sv
// Shared definitions for the cost magnitude averager: FSM state encoding,
// default datapath width and the sq_done timeout counter width.
package cost_pkg;

    localparam int unsigned MAG_WIDTH_DEF = 13;
    localparam int unsigned TMO_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SMP = 3'd1,
        ST_LOAD     = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/mag_avg_acc.sv
// Accumulator, sample counter and shift-divide for the magnitude averager.
// Optional peak tracker enabled by COST_PEAK_TRACK_EN.
module mag_avg_acc
    import cost_pkg::*;
#(
    parameter int unsigned MAG_WIDTH = MAG_WIDTH_DEF,
    parameter int unsigned LOG_AVG   = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 clr,
    input  logic                 add,
    input  logic [MAG_WIDTH-1:0] fout,
    output logic                 last,
    output logic [MAG_WIDTH-1:0] avg_next,
    output logic [MAG_WIDTH-1:0] peak
);

    localparam int unsigned AW = MAG_WIDTH + LOG_AVG;

    logic [AW-1:0]      acc_q, acc_d, acc_sum;
    logic [LOG_AVG-1:0] cnt_q, cnt_d;

    // avg_next already includes the sample being added, so the top can
    // register the mean on the same edge that consumes the last sq_done.
    assign acc_sum  = acc_q + AW'(fout);
    assign avg_next = acc_sum[AW-1:LOG_AVG];
    assign last     = add && (cnt_q == '1);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef COST_PEAK_TRACK_EN
    logic [MAG_WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (clr) begin
            peak_d = '0;
        end else if (add && (fout > peak_q)) begin
            peak_d = fout;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: rtl/cost_mag_accum.sv
// Sequences samples into the CORDIC magnitude stage and averages 2^LOG_AVG
// results into the SA cost value. Peak tracking optional via COST_PEAK_TRACK_EN.
module cost_mag_accum
    import cost_pkg::*;
#(
    parameter int unsigned MAG_WIDTH  = MAG_WIDTH_DEF,
    parameter int unsigned LOG_AVG    = 2,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 smp_valid,
    output logic                 smp_ready,
    input  logic [MAG_WIDTH-1:0] smp_x,
    input  logic [MAG_WIDTH-1:0] smp_y,
    output logic [MAG_WIDTH-1:0] sq_x,
    output logic [MAG_WIDTH-1:0] sq_y,
    output logic                 sq_enable,
    input  logic [MAG_WIDTH-1:0] sq_fout,
    input  logic                 sq_done,
    output logic [MAG_WIDTH-1:0] cost,
    output logic                 cost_valid,
    output logic                 busy,
    output logic                 err,
    output logic [MAG_WIDTH-1:0] peak
);

    state_e               state_q, state_d;
    logic                 smp_ready_q, smp_ready_d;
    logic [MAG_WIDTH-1:0] sq_x_q, sq_x_d;
    logic [MAG_WIDTH-1:0] sq_y_q, sq_y_d;
    logic                 sq_enable_q, sq_enable_d;
    logic [MAG_WIDTH-1:0] cost_q, cost_d;
    logic                 cost_valid_q, cost_valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic                 start_acc;
    logic                 add;
    logic                 last;
    logic [MAG_WIDTH-1:0] avg_next;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign add       = (state_q == ST_RUN) && sq_done;

    mag_avg_acc #(
        .MAG_WIDTH (MAG_WIDTH),
        .LOG_AVG   (LOG_AVG)
    ) u_acc (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (start_acc),
        .add      (add),
        .fout     (sq_fout),
        .last     (last),
        .avg_next (avg_next),
        .peak     (peak)
    );

    always_comb begin
        state_d      = state_q;
        sq_x_d       = sq_x_q;
        sq_y_d       = sq_y_q;
        cost_d       = cost_q;
        cost_valid_d = 1'b0;
        err_d        = err_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_SMP;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT_SMP: begin
                if (smp_valid) begin
                    sq_x_d  = smp_x;
                    sq_y_d  = smp_y;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tmo_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sq_done) begin
                    if (last) begin
                        cost_d       = avg_next;
                        cost_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_SMP;
                    end
                end else if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                    // tmo_q counts completed RUN cycles; this is the last one allowed
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered images of the next state.
        smp_ready_d = (state_d == ST_WAIT_SMP);
        sq_enable_d = (state_d != ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            smp_ready_q  <= 1'b0;
            sq_x_q       <= '0;
            sq_y_q       <= '0;
            sq_enable_q  <= 1'b1;
            cost_q       <= '0;
            cost_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            smp_ready_q  <= smp_ready_d;
            sq_x_q       <= sq_x_d;
            sq_y_q       <= sq_y_d;
            sq_enable_q  <= sq_enable_d;
            cost_q       <= cost_d;
            cost_valid_q <= cost_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign smp_ready  = smp_ready_q;
    assign sq_x       = sq_x_q;
    assign sq_y       = sq_y_q;
    assign sq_enable  = sq_enable_q;
    assign cost       = cost_q;
    assign cost_valid = cost_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: doc/cost_mag_accum.md
# cost_mag_accum

Sequencer and averager directly downstream of the CORDIC magnitude stage (sqrt of offset-corrected power sum). It accepts ADC coordinate pairs over a valid/ready handshake and forwards each pair to the magnitude stage. It drives that stage's enable protocol, collects 2^LOG_AVG magnitude results, and emits their truncated mean as the cost value consumed by the SA cost-evaluation logic.

## Interface
- MAG_WIDTH, 13: width of coordinates and of magnitude result.
- LOG_AVG, 2: log2 of samples averaged per measurement (1..6).
- TMO_CYCLES, 255: max cycles waited for sq_done per sample (8-bit counter).
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a measurement.
- smp_valid  in  1  upstream sample valid.
- smp_ready  out  1  block ready to take a sample.
- smp_x, smp_y  in  MAG_WIDTH  coordinate pair.
- sq_x, sq_y  out  MAG_WIDTH  registered pair driven to magnitude stage.
- sq_enable  out  1  magnitude-stage enable; low = load, high = run.
- sq_fout  in  MAG_WIDTH  magnitude result.
- sq_done  in  1  one-cycle magnitude done pulse.
- cost  out  MAG_WIDTH  averaged magnitude; holds until next cost_valid.
- cost_valid  out  1  one-cycle pulse, cost updated.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.
- peak  out  MAG_WIDTH  max magnitude of last measurement (macro only).

## Operation
- States: IDLE, WAIT_SMP, LOAD, RUN, DONE.
- IDLE: start=1 → WAIT_SMP; acc, sample count and err cleared; peak cleared.
- WAIT_SMP: smp_ready=1; on smp_valid&&smp_ready, latch smp_x/smp_y into sq_x/sq_y → LOAD.
- LOAD: sq_enable=0 for exactly one cycle; sq_done ignored → RUN.
- RUN: sq_enable=1; timeout counter increments each cycle. When sq_done=1: acc += zero-extended sq_fout and count++. If count reached 2^LOG_AVG → DONE, else → WAIT_SMP. If counter reaches TMO_CYCLES without done: err=1 → IDLE, no cost_valid.
- DONE: cost <= acc[MAG_WIDTH+LOG_AVG-1:LOG_AVG] (truncating), cost_valid=1 → IDLE.
- acc width MAG_WIDTH+LOG_AVG; overflow impossible by construction.
- start while busy: ignored. start in same cycle as DONE: ignored.
- err clears only when a new start is accepted.

## Timing
- Reset values: smp_ready=0, sq_x=sq_y=0, sq_enable=1, cost=0, cost_valid=0, busy=0, err=0, peak=0; state IDLE.
- start→smp_ready high: 1 cycle. Sample handshake→sq_enable low: 1 cycle. sq_enable low width: 1 cycle.
- sq_done→next smp_ready: 1 cycle. Last sq_done→cost_valid: 1 cycle (DONE state). cost_valid→busy low: same edge.
- Timeout fires on the cycle the counter equals TMO_CYCLES; counter resets on entry to RUN.
- Reset asserted mid-measurement: all outputs return to reset values asynchronously; partial acc discarded; sq_enable=1 leaves the magnitude stage idle.

## Configuration
- COST_PEAK_TRACK_EN defined: peak register updated in RUN on each sq_done when sq_fout > peak; valid at cost_valid; cleared on accepted start.
- Not defined: peak port tied to 0, no comparator or register.

## Structure
- Shared package cost_pkg: state encoding constants, MAG_WIDTH default, TMO counter width.
- One sub-module: mag_avg_acc (accumulator, sample counter, shift-divide, optional peak tracker); FSM and handshake in the top.

## Test plan
- Bench uses a behavioural magnitude model: done 20 cycles after enable rises, fout from list.
- LOG_AVG=2, fouts 100,101,102,103 → cost=101, cost_valid one pulse, err=0, peak=103 with macro.
- fouts 3,3,3,4 → sum 13 → cost=3 (truncation); without macro peak=0.
- smp_valid withheld 50 cycles between samples → smp_ready stays high, sq_enable stays high, result unchanged.
- Model never returns done → err=1 exactly TMO_CYCLES cycles into RUN, busy falls, no cost_valid; next start clears err.
- start pulsed during RUN → ignored, single measurement; RST_N low mid-RUN → reset values immediately, next start runs clean measurement.
